// File: rtl/axi4lite_arb_2x1.sv
// Purpose: shares one AXI4-Lite slave between two masters, independent RR write/read arbiters.
// Latency: 1 cycle request-to-forward, then zero-latency pass-through; one outstanding per path.
// Backpressure: slave READY passes straight to the granted master; the loser sees READY=0.
// Ports: A_CLK/A_RSTn (async active-low); s0_*/s1_* upstream slave-side channels for masters 0/1;
//        m_* downstream master-side channels toward the shared slave.
module axi4lite_arb_2x1 #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
) (
   input  logic                      A_CLK,
   input  logic                      A_RSTn,
   // upstream master 0
   input  logic                      s0_aw_valid,
   output logic                      s0_aw_ready,
   input  logic [AXI_ADDR_WIDTH-1:0] s0_aw_addr,
   input  logic [2:0]                s0_aw_prot,
   input  logic                      s0_w_valid,
   output logic                      s0_w_ready,
   input  logic [AXI_DATA_WIDTH-1:0] s0_w_data,
   input  logic [AXI_STRB_WIDTH-1:0] s0_w_strb,
   output logic                      s0_b_valid,
   output logic [1:0]                s0_b_resp,
   input  logic                      s0_b_ready,
   input  logic                      s0_ar_valid,
   output logic                      s0_ar_ready,
   input  logic [AXI_ADDR_WIDTH-1:0] s0_ar_addr,
   input  logic [2:0]                s0_ar_prot,
   output logic                      s0_r_valid,
   output logic [AXI_DATA_WIDTH-1:0] s0_r_data,
   output logic [1:0]                s0_r_resp,
   input  logic                      s0_r_ready,
   // upstream master 1
   input  logic                      s1_aw_valid,
   output logic                      s1_aw_ready,
   input  logic [AXI_ADDR_WIDTH-1:0] s1_aw_addr,
   input  logic [2:0]                s1_aw_prot,
   input  logic                      s1_w_valid,
   output logic                      s1_w_ready,
   input  logic [AXI_DATA_WIDTH-1:0] s1_w_data,
   input  logic [AXI_STRB_WIDTH-1:0] s1_w_strb,
   output logic                      s1_b_valid,
   output logic [1:0]                s1_b_resp,
   input  logic                      s1_b_ready,
   input  logic                      s1_ar_valid,
   output logic                      s1_ar_ready,
   input  logic [AXI_ADDR_WIDTH-1:0] s1_ar_addr,
   input  logic [2:0]                s1_ar_prot,
   output logic                      s1_r_valid,
   output logic [AXI_DATA_WIDTH-1:0] s1_r_data,
   output logic [1:0]                s1_r_resp,
   input  logic                      s1_r_ready,
   // downstream shared slave
   output logic                      m_aw_valid,
   input  logic                      m_aw_ready,
   output logic [AXI_ADDR_WIDTH-1:0] m_aw_addr,
   output logic [2:0]                m_aw_prot,
   output logic                      m_w_valid,
   input  logic                      m_w_ready,
   output logic [AXI_DATA_WIDTH-1:0] m_w_data,
   output logic [AXI_STRB_WIDTH-1:0] m_w_strb,
   input  logic                      m_b_valid,
   input  logic [1:0]                m_b_resp,
   output logic                      m_b_ready,
   output logic                      m_ar_valid,
   input  logic                      m_ar_ready,
   output logic [AXI_ADDR_WIDTH-1:0] m_ar_addr,
   output logic [2:0]                m_ar_prot,
   input  logic                      m_r_valid,
   input  logic [AXI_DATA_WIDTH-1:0] m_r_data,
   input  logic [1:0]                m_r_resp,
   output logic                      m_r_ready
);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;
   logic     wgnt, wgnt_nxt, wptr, wptr_nxt;
   logic     rgnt, rgnt_nxt, rptr, rptr_nxt;
   logic     aw_done, aw_done_nxt, w_done, w_done_nxt;

   logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = m_aw_valid & m_aw_ready;
   assign w_hs  = m_w_valid  & m_w_ready;
   assign b_hs  = m_b_valid  & m_b_ready;
   assign ar_hs = m_ar_valid & m_ar_ready;
   assign r_hs  = m_r_valid  & m_r_ready;

   // state register
   always_ff @(posedge A_CLK or negedge A_RSTn) begin
      if (!A_RSTn) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         wgnt    <= 1'b0;
         wptr    <= 1'b0;
         rgnt    <= 1'b0;
         rptr    <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         r_state <= r_state_nxt;
         wgnt    <= wgnt_nxt;
         wptr    <= wptr_nxt;
         rgnt    <= rgnt_nxt;
         rptr    <= rptr_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = w_state;
      wgnt_nxt    = wgnt;
      wptr_nxt    = wptr;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      case (w_state)
         W_IDLE: if (s0_aw_valid || s1_aw_valid) begin
            // tie goes to the pointer, otherwise the lone requester
            wgnt_nxt    = (s0_aw_valid && s1_aw_valid) ? wptr : s1_aw_valid;
            w_state_nxt = W_ADDR;
         end
         W_ADDR: begin
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               w_state_nxt = W_RESP;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end else begin
               aw_done_nxt = aw_done | aw_hs;
               w_done_nxt  = w_done  | w_hs;
            end
         end
         W_RESP: if (b_hs) begin
            w_state_nxt = W_IDLE;
            wptr_nxt    = ~wgnt;
         end
         default: w_state_nxt = W_IDLE;
      endcase

      r_state_nxt = r_state;
      rgnt_nxt    = rgnt;
      rptr_nxt    = rptr;
      case (r_state)
         R_IDLE: if (s0_ar_valid || s1_ar_valid) begin
            rgnt_nxt    = (s0_ar_valid && s1_ar_valid) ? rptr : s1_ar_valid;
            r_state_nxt = R_ADDR;
         end
         R_ADDR: if (ar_hs) r_state_nxt = R_RESP;
         R_RESP: if (r_hs) begin
            r_state_nxt = R_IDLE;
            rptr_nxt    = ~rgnt;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // output routing; a channel whose handshake is already recorded is no
   // longer forwarded, so the slave never sees a duplicate AW or W beat
   always_comb begin
      s0_aw_ready = 1'b0; s0_w_ready = 1'b0; s0_b_valid = 1'b0; s0_b_resp = '0;
      s0_ar_ready = 1'b0; s0_r_valid = 1'b0; s0_r_data = '0;  s0_r_resp = '0;
      s1_aw_ready = 1'b0; s1_w_ready = 1'b0; s1_b_valid = 1'b0; s1_b_resp = '0;
      s1_ar_ready = 1'b0; s1_r_valid = 1'b0; s1_r_data = '0;  s1_r_resp = '0;
      m_aw_valid = 1'b0; m_aw_addr = '0; m_aw_prot = '0;
      m_w_valid  = 1'b0; m_w_data  = '0; m_w_strb  = '0; m_b_ready = 1'b0;
      m_ar_valid = 1'b0; m_ar_addr = '0; m_ar_prot = '0; m_r_ready = 1'b0;

      if (w_state == W_ADDR) begin
         if (!aw_done) begin
            m_aw_valid = wgnt ? s1_aw_valid : s0_aw_valid;
            m_aw_addr  = wgnt ? s1_aw_addr  : s0_aw_addr;
            m_aw_prot  = wgnt ? s1_aw_prot  : s0_aw_prot;
            if (wgnt) s1_aw_ready = m_aw_ready; else s0_aw_ready = m_aw_ready;
         end
         if (!w_done) begin
            m_w_valid = wgnt ? s1_w_valid : s0_w_valid;
            m_w_data  = wgnt ? s1_w_data  : s0_w_data;
            m_w_strb  = wgnt ? s1_w_strb  : s0_w_strb;
            if (wgnt) s1_w_ready = m_w_ready; else s0_w_ready = m_w_ready;
         end
      end else if (w_state == W_RESP) begin
         m_b_ready = wgnt ? s1_b_ready : s0_b_ready;
         if (wgnt) begin s1_b_valid = m_b_valid; s1_b_resp = m_b_resp; end
         else      begin s0_b_valid = m_b_valid; s0_b_resp = m_b_resp; end
      end

      if (r_state == R_ADDR) begin
         m_ar_valid = rgnt ? s1_ar_valid : s0_ar_valid;
         m_ar_addr  = rgnt ? s1_ar_addr  : s0_ar_addr;
         m_ar_prot  = rgnt ? s1_ar_prot  : s0_ar_prot;
         if (rgnt) s1_ar_ready = m_ar_ready; else s0_ar_ready = m_ar_ready;
      end else if (r_state == R_RESP) begin
         m_r_ready = rgnt ? s1_r_ready : s0_r_ready;
         if (rgnt) begin s1_r_valid = m_r_valid; s1_r_data = m_r_data; s1_r_resp = m_r_resp; end
         else      begin s0_r_valid = m_r_valid; s0_r_data = m_r_data; s0_r_resp = m_r_resp; end
      end
   end

endmodule

// File: tb/tb_axi4lite_arb_2x1.sv
// Purpose: directed self-checking bench for the 2x1 AXI4-Lite arbiter.
// Latency: inputs driven 2ns after the rising edge, outputs sampled mid-cycle.
// Backpressure: the bench plays both masters and the shared slave by hand.
module tb_axi4lite_arb_2x1;

   logic        A_CLK, A_RSTn;
   logic        s0_aw_valid, s0_aw_ready, s0_w_valid, s0_w_ready, s0_b_valid, s0_b_ready;
   logic        s0_ar_valid, s0_ar_ready, s0_r_valid, s0_r_ready;
   logic [31:0] s0_aw_addr, s0_w_data, s0_ar_addr, s0_r_data;
   logic [2:0]  s0_aw_prot, s0_ar_prot;
   logic [3:0]  s0_w_strb;
   logic [1:0]  s0_b_resp, s0_r_resp;
   logic        s1_aw_valid, s1_aw_ready, s1_w_valid, s1_w_ready, s1_b_valid, s1_b_ready;
   logic        s1_ar_valid, s1_ar_ready, s1_r_valid, s1_r_ready;
   logic [31:0] s1_aw_addr, s1_w_data, s1_ar_addr, s1_r_data;
   logic [2:0]  s1_aw_prot, s1_ar_prot;
   logic [3:0]  s1_w_strb;
   logic [1:0]  s1_b_resp, s1_r_resp;
   logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
   logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
   logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
   logic [2:0]  m_aw_prot, m_ar_prot;
   logic [3:0]  m_w_strb;
   logic [1:0]  m_b_resp, m_r_resp;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   axi4lite_arb_2x1 dut (
      .A_CLK(A_CLK), .A_RSTn(A_RSTn),
      .s0_aw_valid(s0_aw_valid), .s0_aw_ready(s0_aw_ready), .s0_aw_addr(s0_aw_addr), .s0_aw_prot(s0_aw_prot),
      .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready), .s0_w_data(s0_w_data), .s0_w_strb(s0_w_strb),
      .s0_b_valid(s0_b_valid), .s0_b_resp(s0_b_resp), .s0_b_ready(s0_b_ready),
      .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr), .s0_ar_prot(s0_ar_prot),
      .s0_r_valid(s0_r_valid), .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp), .s0_r_ready(s0_r_ready),
      .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready), .s1_aw_addr(s1_aw_addr), .s1_aw_prot(s1_aw_prot),
      .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready), .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb),
      .s1_b_valid(s1_b_valid), .s1_b_resp(s1_b_resp), .s1_b_ready(s1_b_ready),
      .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr), .s1_ar_prot(s1_ar_prot),
      .s1_r_valid(s1_r_valid), .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp), .s1_r_ready(s1_r_ready),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_b_valid(m_b_valid), .m_b_resp(m_b_resp), .m_b_ready(m_b_ready),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
      .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_ready(m_r_ready)
   );

   initial begin
      A_CLK = 1'b0;
      forever #5 A_CLK = ~A_CLK;
   end

   task automatic tick();
      @(posedge A_CLK);
      #2;
      cyc++;
   endtask

   task automatic clear_inputs();
      s0_aw_valid = 0; s0_aw_addr = 0; s0_aw_prot = 0; s0_w_valid = 0; s0_w_data = 0; s0_w_strb = 0;
      s0_b_ready = 0; s0_ar_valid = 0; s0_ar_addr = 0; s0_ar_prot = 0; s0_r_ready = 0;
      s1_aw_valid = 0; s1_aw_addr = 0; s1_aw_prot = 0; s1_w_valid = 0; s1_w_data = 0; s1_w_strb = 0;
      s1_b_ready = 0; s1_ar_valid = 0; s1_ar_addr = 0; s1_ar_prot = 0; s1_r_ready = 0;
      m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_resp = 0;
      m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_resp = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      A_RSTn = 0;
      tick();
      tick();
      A_RSTn = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      A_RSTn = 0;
      #1;
      checks++; if (m_aw_valid !== 1'b0) begin failures++; $display("FAIL rst_m_aw_valid got=%b exp=0", m_aw_valid); end
      // requests and slave responses while reset is held must not leak through
      s0_aw_valid = 1; s0_w_valid = 1; s1_ar_valid = 1; m_b_valid = 1; m_r_valid = 1; m_r_data = 32'hFFFF_FFFF;
      m_aw_ready = 1; m_ar_ready = 1;
      tick(); tick();
      checks++; if (m_aw_valid !== 1'b0 || m_ar_valid !== 1'b0 || m_w_valid !== 1'b0) begin
         failures++; $display("FAIL rst_m_valids got=%b%b%b exp=000", m_aw_valid, m_w_valid, m_ar_valid); end
      checks++; if (s0_b_valid !== 1'b0 || s1_r_valid !== 1'b0 || s1_r_data !== 32'h0) begin
         failures++; $display("FAIL rst_s_resp got b=%b r=%b d=%h exp 0", s0_b_valid, s1_r_valid, s1_r_data); end
      checks++; if (s0_aw_ready !== 1'b0 || s1_ar_ready !== 1'b0 || m_b_ready !== 1'b0 || m_r_ready !== 1'b0) begin
         failures++; $display("FAIL rst_readys got=%b%b%b%b exp=0000", s0_aw_ready, s1_ar_ready, m_b_ready, m_r_ready); end
   endtask

   task automatic test_single_write();
      do_reset();
      s0_aw_valid = 1; s0_aw_addr = 32'h10; s0_w_valid = 1; s0_w_data = 32'hDEADBEEF; s0_w_strb = 4'hF; s0_b_ready = 1;
      #1;
      checks++; if (m_aw_valid !== 1'b0) begin failures++; $display("FAIL sw_idle_no_fwd got=%b exp=0", m_aw_valid); end
      tick();
      checks++; if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h10) begin
         failures++; $display("FAIL sw_aw_fwd got v=%b a=%h exp v=1 a=10", m_aw_valid, m_aw_addr); end
      checks++; if (m_w_valid !== 1'b1 || m_w_data !== 32'hDEADBEEF || m_w_strb !== 4'hF) begin
         failures++; $display("FAIL sw_w_fwd got v=%b d=%h s=%h exp 1 deadbeef f", m_w_valid, m_w_data, m_w_strb); end
      m_aw_ready = 1; m_w_ready = 1;
      #1;
      checks++; if (s0_aw_ready !== 1'b1 || s0_w_ready !== 1'b1) begin
         failures++; $display("FAIL sw_s0_ready got=%b%b exp=11", s0_aw_ready, s0_w_ready); end
      checks++; if (s1_aw_ready !== 1'b0 || s1_w_ready !== 1'b0) begin
         failures++; $display("FAIL sw_s1_ready got=%b%b exp=00", s1_aw_ready, s1_w_ready); end
      tick();
      s0_aw_valid = 0; s0_w_valid = 0; m_aw_ready = 0; m_w_ready = 0; m_b_valid = 1; m_b_resp = 2'b00;
      #1;
      checks++; if (s0_b_valid !== 1'b1 || s0_b_resp !== 2'b00 || m_b_ready !== 1'b1) begin
         failures++; $display("FAIL sw_b_route got v=%b r=%b rdy=%b exp 1 00 1", s0_b_valid, s0_b_resp, m_b_ready); end
      checks++; if (s1_b_valid !== 1'b0 || m_aw_valid !== 1'b0) begin
         failures++; $display("FAIL sw_resp_iso got s1b=%b maw=%b exp 0 0", s1_b_valid, m_aw_valid); end
      tick();
      m_b_valid = 0;
      #1;
      checks++; if (s0_b_valid !== 1'b0) begin failures++; $display("FAIL sw_b_done got=%b exp=0", s0_b_valid); end
   endtask

   task automatic test_contention_write();
      do_reset();
      s0_aw_valid = 1; s0_aw_addr = 32'h0; s0_w_valid = 1; s0_w_data = 32'hA0A0_A0A0; s0_w_strb = 4'hF; s0_b_ready = 1;
      s1_aw_valid = 1; s1_aw_addr = 32'h4; s1_w_valid = 1; s1_w_data = 32'hB1B1_B1B1; s1_w_strb = 4'hF; s1_b_ready = 1;
      m_aw_ready = 1; m_w_ready = 1;
      tick();
      checks++; if (m_aw_addr !== 32'h0 || m_w_data !== 32'hA0A0_A0A0 || s0_aw_ready !== 1'b1 || s1_aw_ready !== 1'b0) begin
         failures++; $display("FAIL cw_first_s0 got a=%h d=%h r0=%b r1=%b exp 0 a0a0a0a0 1 0", m_aw_addr, m_w_data, s0_aw_ready, s1_aw_ready); end
      tick();
      s0_aw_valid = 0; s0_w_valid = 0; m_b_valid = 1; m_b_resp = 2'b00;
      #1;
      checks++; if (s0_b_valid !== 1'b1 || s1_b_valid !== 1'b0) begin
         failures++; $display("FAIL cw_b0 got s0=%b s1=%b exp 1 0", s0_b_valid, s1_b_valid); end
      tick();
      m_b_valid = 0;
      #1;
      checks++; if (m_aw_valid !== 1'b0) begin failures++; $display("FAIL cw_idle_gap got=%b exp=0", m_aw_valid); end
      tick();
      checks++; if (m_aw_addr !== 32'h4 || m_w_data !== 32'hB1B1_B1B1 || s1_aw_ready !== 1'b1 || s0_aw_ready !== 1'b0) begin
         failures++; $display("FAIL cw_second_s1 got a=%h d=%h r1=%b r0=%b exp 4 b1b1b1b1 1 0", m_aw_addr, m_w_data, s1_aw_ready, s0_aw_ready); end
      tick();
      s1_aw_valid = 0; s1_w_valid = 0; m_b_valid = 1;
      #1;
      checks++; if (s1_b_valid !== 1'b1 || s1_b_resp !== 2'b00 || s0_b_valid !== 1'b0) begin
         failures++; $display("FAIL cw_b1 got s1=%b r=%b s0=%b exp 1 00 0", s1_b_valid, s1_b_resp, s0_b_valid); end
      tick();
      m_b_valid = 0;
      // pointer must be back on master 0: a fresh tie goes to s0
      s0_aw_valid = 1; s0_aw_addr = 32'h8; s0_w_valid = 1;
      s1_aw_valid = 1; s1_aw_addr = 32'hC; s1_w_valid = 1;
      m_aw_ready = 0; m_w_ready = 0;
      tick();
      checks++; if (m_aw_addr !== 32'h8) begin failures++; $display("FAIL cw_wptr_back0 got=%h exp=8", m_aw_addr); end
   endtask

   task automatic test_read_contention();
      int n0, n1, last, w;
      logic exp_m;
      logic [31:0] exp_addr, exp_data;
      do_reset();
      n0 = 0; n1 = 0; last = 0;
      s0_ar_valid = 1; s0_ar_addr = 32'h100; s0_r_ready = 1;
      s1_ar_valid = 1; s1_ar_addr = 32'h200; s1_r_ready = 1;
      m_ar_ready = 1;
      for (int k = 0; k < 8; k++) begin
         exp_m = k[0];
         exp_addr = exp_m ? (32'h200 + 32'(4*n1)) : (32'h100 + 32'(4*n0));
         exp_data = {16'hDA7A, exp_addr[15:0]};
         w = 0;
         while (m_ar_valid !== 1'b1 && w < 5) begin tick(); w++; end
         checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== exp_addr) begin
            failures++; $display("FAIL rc_ar_%0d got v=%b a=%h exp v=1 a=%h", k, m_ar_valid, m_ar_addr, exp_addr); end
         checks++; if ((exp_m ? s1_ar_ready : s0_ar_ready) !== 1'b1 || (exp_m ? s0_ar_ready : s1_ar_ready) !== 1'b0) begin
            failures++; $display("FAIL rc_ar_ready_%0d got r0=%b r1=%b exp owner=%0d", k, s0_ar_ready, s1_ar_ready, exp_m); end
         if (k > 0) begin
            checks++; if (cyc - last !== 3) begin
               failures++; $display("FAIL rc_spacing_%0d got=%0d exp=3", k, cyc - last); end
         end
         last = cyc;
         tick();
         if (exp_m) begin
            n1++;
            if (n1 == 4) s1_ar_valid = 0; else s1_ar_addr = 32'h200 + 32'(4*n1);
         end else begin
            n0++;
            if (n0 == 4) s0_ar_valid = 0; else s0_ar_addr = 32'h100 + 32'(4*n0);
         end
         m_r_valid = 1; m_r_data = exp_data; m_r_resp = 2'b00;
         #1;
         checks++; if ((exp_m ? s1_r_valid : s0_r_valid) !== 1'b1 || (exp_m ? s1_r_data : s0_r_data) !== exp_data ||
                       (exp_m ? s0_r_valid : s1_r_valid) !== 1'b0) begin
            failures++; $display("FAIL rc_r_route_%0d got v0=%b v1=%b d0=%h d1=%h exp owner=%0d d=%h",
                                 k, s0_r_valid, s1_r_valid, s0_r_data, s1_r_data, exp_m, exp_data); end
         tick();
         m_r_valid = 0;
      end
   endtask

   task automatic test_w_before_aw();
      do_reset();
      s1_w_valid = 1; s1_w_data = 32'hCAFEF00D; s1_w_strb = 4'h3; s1_b_ready = 1; m_w_ready = 1;
      #1;
      checks++; if (m_w_valid !== 1'b0) begin failures++; $display("FAIL wb_no_grant0 got=%b exp=0", m_w_valid); end
      tick();
      checks++; if (m_w_valid !== 1'b0 || s1_w_ready !== 1'b0) begin
         failures++; $display("FAIL wb_no_grant1 got v=%b r=%b exp 0 0", m_w_valid, s1_w_ready); end
      tick();
      s1_aw_valid = 1; s1_aw_addr = 32'h40;
      tick();
      checks++; if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h40 || m_w_data !== 32'hCAFEF00D || m_w_strb !== 4'h3) begin
         failures++; $display("FAIL wb_fwd got v=%b a=%h d=%h s=%h exp 1 40 cafef00d 3", m_aw_valid, m_aw_addr, m_w_data, m_w_strb); end
      checks++; if (s1_w_ready !== 1'b1 || s1_aw_ready !== 1'b0) begin
         failures++; $display("FAIL wb_w_first got wr=%b awr=%b exp 1 0", s1_w_ready, s1_aw_ready); end
      tick();
      s1_w_valid = 0;
      #1;
      checks++; if (m_w_valid !== 1'b0 || m_aw_valid !== 1'b1) begin
         failures++; $display("FAIL wb_w_sticky got wv=%b awv=%b exp 0 1", m_w_valid, m_aw_valid); end
      tick();
      m_aw_ready = 1;
      #1;
      checks++; if (s1_aw_ready !== 1'b1) begin failures++; $display("FAIL wb_aw_ready got=%b exp=1", s1_aw_ready); end
      tick();
      s1_aw_valid = 0; m_aw_ready = 0; m_b_valid = 1; m_b_resp = 2'b00;
      #1;
      checks++; if (s1_b_valid !== 1'b1 || s0_b_valid !== 1'b0) begin
         failures++; $display("FAIL wb_b_pulse got s1=%b s0=%b exp 1 0", s1_b_valid, s0_b_valid); end
      tick();
      m_b_valid = 0;
      tick();
      m_b_valid = 1;
      #1;
      checks++; if (s1_b_valid !== 1'b0) begin failures++; $display("FAIL wb_single_b got=%b exp=0", s1_b_valid); end
      m_b_valid = 0;
   endtask

   task automatic test_concurrent();
      do_reset();
      s0_aw_valid = 1; s0_aw_addr = 32'h20; s0_w_valid = 1; s0_w_data = 32'h1111_2222; s0_w_strb = 4'hF; s0_b_ready = 1;
      s1_ar_valid = 1; s1_ar_addr = 32'h30; s1_r_ready = 1;
      m_aw_ready = 1; m_w_ready = 1; m_ar_ready = 1;
      tick();
      checks++; if (m_aw_addr !== 32'h20 || m_ar_addr !== 32'h30 || m_aw_valid !== 1'b1 || m_ar_valid !== 1'b1) begin
         failures++; $display("FAIL cc_parallel got aw=%h ar=%h v=%b%b exp 20 30 11", m_aw_addr, m_ar_addr, m_aw_valid, m_ar_valid); end
      checks++; if (s0_aw_ready !== 1'b1 || s1_ar_ready !== 1'b1 || s0_ar_ready !== 1'b0 || s1_aw_ready !== 1'b0) begin
         failures++; $display("FAIL cc_readys got %b%b%b%b exp 1100", s0_aw_ready, s1_ar_ready, s0_ar_ready, s1_aw_ready); end
      tick();
      s0_aw_valid = 0; s0_w_valid = 0; s1_ar_valid = 0;
      m_b_valid = 1; m_b_resp = 2'b00; m_r_valid = 1; m_r_resp = 2'b10; m_r_data = 32'h0000_55AA;
      #1;
      checks++; if (s1_r_valid !== 1'b1 || s1_r_resp !== 2'b10 || s1_r_data !== 32'h0000_55AA) begin
         failures++; $display("FAIL cc_slverr got v=%b r=%b d=%h exp 1 10 000055aa", s1_r_valid, s1_r_resp, s1_r_data); end
      checks++; if (s0_b_valid !== 1'b1 || s0_b_resp !== 2'b00 || s0_r_valid !== 1'b0 || s1_b_valid !== 1'b0) begin
         failures++; $display("FAIL cc_bresp got b0=%b r=%b r0v=%b b1=%b exp 1 00 0 0", s0_b_valid, s0_b_resp, s0_r_valid, s1_b_valid); end
      tick();
      m_b_valid = 0; m_r_valid = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      s0_aw_valid = 1; s0_aw_addr = 32'h50; s0_w_valid = 1; s0_w_data = 32'h1234; s0_w_strb = 4'hF; s0_b_ready = 1;
      m_aw_ready = 1; m_w_ready = 1;
      tick();
      tick();
      s0_aw_valid = 0; s0_w_valid = 0; m_b_valid = 1; m_b_resp = 2'b01;
      #1;
      checks++; if (s0_b_valid !== 1'b1 || s0_b_resp !== 2'b01) begin
         failures++; $display("FAIL rm_pre got v=%b r=%b exp 1 01", s0_b_valid, s0_b_resp); end
      A_RSTn = 0;
      #1;
      checks++; if (s0_b_valid !== 1'b0 || s0_b_resp !== 2'b00 || m_b_ready !== 1'b0) begin
         failures++; $display("FAIL rm_async got v=%b r=%b rdy=%b exp 0 00 0", s0_b_valid, s0_b_resp, m_b_ready); end
      m_b_valid = 0; s0_b_ready = 0;
      #1;
      A_RSTn = 1;
      s1_aw_valid = 1; s1_aw_addr = 32'h60; s1_w_valid = 1; s1_w_data = 32'h5678; s1_w_strb = 4'hF; s1_b_ready = 1;
      tick();
      checks++; if (m_aw_addr !== 32'h60 || s1_aw_ready !== 1'b1 || s0_aw_ready !== 1'b0) begin
         failures++; $display("FAIL rm_regrant got a=%h r1=%b r0=%b exp 60 1 0", m_aw_addr, s1_aw_ready, s0_aw_ready); end
      tick();
      s1_aw_valid = 0; s1_w_valid = 0; m_b_valid = 1; m_b_resp = 2'b00;
      #1;
      checks++; if (s1_b_valid !== 1'b1 || s0_b_valid !== 1'b0) begin
         failures++; $display("FAIL rm_b1 got s1=%b s0=%b exp 1 0", s1_b_valid, s0_b_valid); end
      tick();
      m_b_valid = 0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention_write();
      test_read_contention();
      test_w_before_aw();
      test_concurrent();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi4lite_arb_2x1.md
# axi4lite_arb_2x1

Two-master, one-slave AXI4-Lite arbiter: shares one downstream AXI4-Lite slave port between two upstream masters, typically a CPU-side master and a DMA/debug master. Write and read paths are arbitrated independently, each with round-robin priority and one outstanding transaction per path. The block sits between two master-side `axi4lite_if` instances and one slave-side `axi4lite_if` instance.

## Interface

Parameters:
- AXI_ADDR_WIDTH, 32, address width, from params.vh.
- AXI_DATA_WIDTH, 32, data width, from params.vh.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width, from params.vh.

Ports:
- A_CLK  input  1  single clock; all state on rising edge.
- A_RSTn  input  1  asynchronous, active-low reset.
- s0  axi4lite_if.slave  bundle  upstream port for master 0; this block acts as slave.
- s1  axi4lite_if.slave  bundle  upstream port for master 1; this block acts as slave.
- m  axi4lite_if.master  bundle  downstream port; this block acts as master toward the shared slave.

## Operation

- Write FSM states: W_IDLE, W_ADDR, W_RESP. Read FSM states: R_IDLE, R_ADDR, R_RESP. The two FSMs are fully independent, and a read and a write may be in flight simultaneously.
- Write request from master i is `si.AW_VALID`. W_VALID alone does not request.
- Read request from master i is `si.AR_VALID`.
- Each FSM has a registered grant `wgnt`/`rgnt` (0 or 1) and a priority pointer `wptr`/`rptr` (0 or 1).
- Arbitration in IDLE:
  - With one requester, that requester wins.
  - With both requesting, the master equal to the pointer wins.
  - Grant is latched and the FSM moves to ADDR.
- Pointer update: when a transaction completes, the pointer is set to the non-granted master (fair alternation).
- W_ADDR:
  - Combinational pass-through between the granted master and m for AW and W: VALID, ADDR, PROT, DATA, STRB forward; READY returns.
  - Two sticky flags, aw_done and w_done, record each handshake; AW and W may complete in either order or in the same cycle.
  - When both flags are set (counting the current cycle), the FSM moves to W_RESP and the flags clear.
- W_RESP:
  - m.B_VALID and m.B_RESP pass to the granted master; its B_READY passes to m.B_READY.
  - On the B handshake the FSM moves to W_IDLE and wptr updates.
- R_ADDR: AR pass-through for the granted master. On the AR handshake the FSM moves to R_RESP.
- R_RESP:
  - m.R_VALID, R_DATA and R_RESP pass to the granted master; its R_READY passes back to m.
  - On the R handshake the FSM moves to R_IDLE and rptr updates.
- Non-granted master, and both masters while in IDLE: AW_READY, W_READY, B_VALID, AR_READY and R_VALID are 0; B_RESP, R_RESP and R_DATA are 0.
- Toward m while in IDLE, and for any channel not currently passed through: all VALID and READY signals are 0; ADDR, PROT, DATA and STRB are 0.
- The arbiter never generates responses. RESP values from the slave, including SLVERR and DECERR, pass through unmodified.

## Timing

- Reset (A_RSTn=0, asynchronous):
  - Both FSMs go to IDLE; wgnt, rgnt, wptr and rptr are 0; aw_done and w_done are 0.
  - All outputs on s0, s1 and m are 0 immediately.
- Arbitration latency: exactly 1 cycle. A request seen in IDLE at edge N drives the forwarded VALID on m during cycle N+1.
- After ADDR, all channels are zero-latency combinational pass-through. No combinational path runs from m back to m, or from one upstream port to the other.
- Back-to-back: after a response handshake the FSM spends one cycle in IDLE. Minimum per-path period is 3 cycles: IDLE, ADDR, RESP.
- Master-side AXI rules hold: once a VALID is forwarded it stays until READY, because the grant cannot change outside IDLE.
- Reset mid-transaction: the transaction is abandoned and no response is delivered. Recovery is the system's responsibility.
- Simultaneous AW and AR from different masters are granted independently in the same cycle.

## Test plan

- Single write from s0: AW addr 0x10, W data 0xDEADBEEF, strb 0xF; slave accepts and returns OKAY. Required: m sees addr 0x10 and data 0xDEADBEEF one cycle after the request; s0.B_RESP=0; s1 sees no READY or VALID at any point.
- Contention write: s0 and s1 both assert AW/W in the same cycle (addresses 0x0 and 0x4) after reset. Required: s0 granted first, then s1, both OKAY; final wptr=0.
- Sustained read contention: s0 and s1 each issue 4 reads continuously. Required: m sees AR addresses alternating s0, s1, s0, s1...; each R_DATA is routed to its issuer; 3-cycle minimum spacing between grants.
- W before AW: s1 asserts W_VALID 2 cycles before AW_VALID; slave holds AW_READY low for 2 cycles. Required: no grant until AW_VALID; data forwarded intact; exactly one B pulse to s1.
- Concurrent read and write: s0 writes while s1 reads in the same cycle; slave returns SLVERR on the read. Required: both proceed in parallel; s1.R_RESP=2'b10 and s0.B_RESP=2'b00.
- Reset asserted in W_RESP with m.B_VALID=1: all outputs go to 0 asynchronously. After release, a new write from s1 is granted normally with wptr=0.
